// File: rtl/approx_serial_add_ctrl.sv
// Bit-serial adder controller: one 1-bit cell walks a WIDTH-bit operand pair LSB first.
// Define APPROX_ADD_EN to use the lower-part-OR approximate cell on the low APPROX_BITS positions.
module approx_serial_add_ctrl #(
  parameter int WIDTH       = 8,
  parameter int APPROX_BITS = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin_in,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout_out
);

  // Handshake: start is taken only on an edge where ready=1 (IDLE); done is a
  // one-cycle pulse, and sum_out/cout_out hold from done until the next accepted start.

  localparam int CW = $clog2(WIDTH);
`ifdef APPROX_ADD_EN
  localparam int NAPPROX = APPROX_BITS;
`else
  localparam int NAPPROX = 0;
`endif
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic             bit_a;
  logic             bit_b;
  logic             approx_bit;
  logic             cell_s;
  logic             cell_co;
  logic [WIDTH-1:0] res_next;

  // Operand registers shift right, so the bit being processed is always at index 0.
  always_comb begin
    bit_a      = a_sh[0];
    bit_b      = b_sh[0];
    approx_bit = (int'(cnt) < NAPPROX);
    cell_s     = 1'b0;
    cell_co    = 1'b0;
    if (approx_bit) begin
      cell_s  = bit_a | bit_b;
      cell_co = bit_a & bit_b;
    end else begin
      cell_s  = bit_a ^ bit_b ^ carry;
      cell_co = (bit_a & bit_b) | (carry & (bit_a ^ bit_b));
    end
    res_next = {cell_s, res_sh[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ready    <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      sum_out  <= '0;
      cout_out <= 1'b0;
      a_sh     <= '0;
      b_sh     <= '0;
      res_sh   <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state    <= RUN;
            ready    <= 1'b0;
            busy     <= 1'b1;
            a_sh     <= a_in;
            b_sh     <= b_in;
            res_sh   <= '0;
            carry    <= cin_in;
            cnt      <= '0;
            sum_out  <= '0;
            cout_out <= 1'b0;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          res_sh <= res_next;
          carry  <= cell_co;
          // The counter is held at its last value rather than incremented, so it never wraps.
          if (cnt == LAST) begin
            state    <= DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            sum_out  <= res_next;
            cout_out <= cell_co;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          ready <= 1'b1;
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_approx_serial_add_ctrl.sv
// Self-checking bench for approx_serial_add_ctrl (WIDTH=8, APPROX_BITS=3); follows APPROX_ADD_EN.
module tb_approx_serial_add_ctrl;
  localparam int W  = 8;
  localparam int AB = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         cin_in;
  logic         ready;
  logic         busy;
  logic         done;
  logic [W-1:0] sum_out;
  logic         cout_out;

  int n_checks = 0;
  int n_fail   = 0;
  logic [W:0] exp_q[$];

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] sum;
    logic         cout;
  } vec_t;
  vec_t vecs[7];

  approx_serial_add_ctrl #(.WIDTH(W), .APPROX_BITS(AB)) dut (
    .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in), .cin_in(cin_in),
    .ready(ready), .busy(busy), .done(done), .sum_out(sum_out), .cout_out(cout_out)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: exact sum is plain addition; approximate sum ORs the low AB bits and feeds
  // the AND of bit AB-1 as carry into an ordinary addition of the upper bits.
  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    longint unsigned av, bv, full, lo_mask, cy;
    av = a;
    bv = b;
    lo_mask = 0;
    cy = c;
`ifdef APPROX_ADD_EN
    lo_mask = (64'd1 << AB) - 64'd1;
    if (AB > 0) cy = ((av & bv) >> (AB - 1)) & 64'd1;
    full = (((av >> AB) + (bv >> AB) + cy) << AB) | ((av | bv) & lo_mask);
`else
    full = av + bv + cy;
`endif
    return full[W:0];
  endfunction

  // driver: one complete addition, result compared against the head of exp_q
  task automatic do_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                        input bit scramble);
    int lat;
    int guard;
    logic [W:0] exp;
    guard = 0;
    while (!ready && guard < 40) begin
      tick();
      guard++;
    end
    check("ready_before_start", ready, 1);
    a_in = a; b_in = b; cin_in = c; start = 1'b1;
    tick();
    start = 1'b0;
    lat = 1;
    check("accept_busy", busy, 1);
    check("accept_clears_result", {cout_out, sum_out}, 0);
    while (!done && lat < 4 * W) begin
      if (scramble && busy) begin
        start  = 1'($urandom_range(0, 1));
        a_in   = W'($urandom);
        b_in   = W'($urandom);
        cin_in = 1'($urandom_range(0, 1));
      end
      tick();
      lat++;
    end
    start = 1'b0;
    check("start_to_done_latency", lat, W + 1);
    if (exp_q.size() == 0) begin
      check("scoreboard_nonempty", 0, 1);
    end else begin
      exp = exp_q.pop_front();
      check("result_cout_sum", {cout_out, sum_out}, exp);
    end
    tick();
    check("done_single_pulse", done, 0);
    check("ready_after_done", ready, 1);
    check("result_held", {cout_out, sum_out}, exp);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a_in = '0; b_in = '0; cin_in = 1'b0;
    repeat (3) tick();
    check("reset_ready", ready, 1);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_sum", sum_out, 0);
    check("reset_cout", cout_out, 0);
    rst = 1'b0;
    tick();

    // table-driven directed vectors
    vecs[0] = '{a: 8'hC8, b: 8'h88, cin: 1'b0, sum: 8'h50, cout: 1'b1};
    vecs[1] = '{a: 8'hA5, b: 8'h5A, cin: 1'b0, sum: 8'hFF, cout: 1'b0};
    vecs[2] = '{a: 8'h00, b: 8'h00, cin: 1'b0, sum: 8'h00, cout: 1'b0};
    vecs[3] = '{a: 8'hFF, b: 8'hFF, cin: 1'b1, sum: 8'hFF, cout: 1'b1};
`ifdef APPROX_ADD_EN
    vecs[4] = '{a: 8'hFF, b: 8'h01, cin: 1'b1, sum: 8'hFF, cout: 1'b0};
    vecs[5] = '{a: 8'h0F, b: 8'h01, cin: 1'b0, sum: 8'h0F, cout: 1'b0};
    vecs[6] = '{a: 8'h00, b: 8'h00, cin: 1'b1, sum: 8'h00, cout: 1'b0};
`else
    vecs[4] = '{a: 8'hFF, b: 8'h01, cin: 1'b1, sum: 8'h01, cout: 1'b1};
    vecs[5] = '{a: 8'h0F, b: 8'h01, cin: 1'b0, sum: 8'h10, cout: 1'b0};
    vecs[6] = '{a: 8'h00, b: 8'h00, cin: 1'b1, sum: 8'h01, cout: 1'b0};
`endif
    for (int i = 0; i < 7; i++) begin
      exp_q.push_back({vecs[i].cout, vecs[i].sum});
      do_add(vecs[i].a, vecs[i].b, vecs[i].cin, 1'b0);
    end

    // randomized operands, half with start/operand noise during RUN
    for (int i = 0; i < 24; i++) begin
      logic [W-1:0] ra, rb;
      logic rc;
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom_range(0, 1));
      exp_q.push_back(model(ra, rb, rc));
      do_add(ra, rb, rc, bit'(i % 2));
    end

    // start held high for 30 cycles
    begin
      int acc[$];
      int busy_cnt, done_cnt, dbl;
      logic prev_done;
      busy_cnt = 0; done_cnt = 0; dbl = 0; prev_done = 1'b0;
      a_in = 8'h3C; b_in = 8'h4B; cin_in = 1'b1; start = 1'b1;
      for (int k = 0; k < 30; k++) begin
        if (ready) acc.push_back(k);
        if (busy) busy_cnt++;
        if (done) begin
          done_cnt++;
          if (prev_done) dbl++;
        end
        prev_done = done;
        tick();
      end
      start = 1'b0;
      check("held_accept_count", acc.size(), 3);
      if (acc.size() >= 3) begin
        check("held_accept_0", acc[0], 0);
        check("held_accept_1", acc[1], 10);
        check("held_accept_2", acc[2], 20);
      end
      check("held_busy_cycles", busy_cnt, 24);
      check("held_done_pulses", done_cnt, 3);
      check("held_done_back_to_back", dbl, 0);
      check("held_result", {cout_out, sum_out}, model(8'h3C, 8'h4B, 1'b1));
    end
    tick();

    // reset in IDLE clears a held nonzero result
    exp_q.push_back(model(8'h5A, 8'h33, 1'b0));
    do_add(8'h5A, 8'h33, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("idle_reset_sum", sum_out, 0);
    check("idle_reset_cout", cout_out, 0);

    // reset during the 4th RUN cycle
    begin
      int done_seen;
      a_in = 8'h77; b_in = 8'h11; cin_in = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      repeat (3) tick();
      check("pre_reset_busy", busy, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("run_reset_ready", ready, 1);
      check("run_reset_busy", busy, 0);
      check("run_reset_sum", sum_out, 0);
      check("run_reset_cout", cout_out, 0);
      done_seen = 0;
      for (int k = 0; k < 12; k++) begin
        if (done || busy) done_seen++;
        tick();
      end
      check("run_reset_no_done", done_seen, 0);
      exp_q.push_back(model(8'hE7, 8'h2D, 1'b1));
      do_add(8'hE7, 8'h2D, 1'b1, 1'b0);
    end

    // rst and start together: rst wins
    a_in = 8'h12; b_in = 8'h34; start = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0;
    check("rst_start_busy", busy, 0);
    check("rst_start_ready", ready, 1);
    tick();
    check("rst_start_still_idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/approx_serial_add_ctrl.md
# approx_serial_add_ctrl

Bit-serial adder controller that sequences a single 1-bit adder cell over a WIDTH-bit operand pair, one bit per clock, with a start/ready/done handshake. The lower APPROX_BITS positions use the approximate cell (lower-part OR) and the upper positions use an exact full adder. The block sits between an operand source (bench or upstream FSM) and a result consumer. It trades latency for area in the approximate-arithmetic datapath.

## Interface
Parameters:
- WIDTH, 8: operand and sum width in bits; valid range 2..32.
- APPROX_BITS, 3: number of LSB positions processed by the approximate cell; valid range 0..WIDTH; used only when APPROX_ADD_EN is defined.

Ports:
- clk  in  1  single system clock; all state changes on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  request a new addition; sampled only when ready=1.
- a_in  in  WIDTH  operand A; captured on the accepted start.
- b_in  in  WIDTH  operand B; captured on the accepted start.
- cin_in  in  1  carry-in; captured on the accepted start.
- ready  out  1  high in IDLE only.
- busy  out  1  high in RUN only.
- done  out  1  one-cycle pulse in DONE state.
- sum_out  out  WIDTH  result; holds its value until the next accepted start or reset.
- cout_out  out  1  final carry; same hold rule as sum_out.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE -> RUN on start=1:
  - load shift registers with a_in and b_in;
  - load the carry register with cin_in;
  - clear the bit counter to 0;
  - clear sum_out and cout_out.
- RUN: each cycle, process bit i = counter.
  - Apply the cell to (a[i], b[i], carry).
  - Shift the sum bit into the MSB of the result register, which shifts right.
  - Update the carry register and increment the counter.
  - At counter = WIDTH-1, go to DONE.
- DONE: done=1, then return unconditionally to IDLE. start is ignored in DONE.
- Exact cell: s = a^b^c, co = (a&b)|(c&(a^b)).
- Approximate cell (i < APPROX_BITS): s = a|b, co = a&b. The incoming carry is ignored.
  - When APPROX_BITS > 0, cin_in therefore has no effect on the result.
  - The carry into bit APPROX_BITS is a&b of bit APPROX_BITS-1.
- cout_out = carry out of bit WIDTH-1, registered at the DONE transition together with the final sum.
- Counter width: clog2(WIDTH). No counter wrap occurs, because RUN always exits at WIDTH-1.
- start while busy or done: ignored, not queued.

## Timing
- Reset values:
  - state = IDLE, ready=1, busy=0, done=0;
  - sum_out=0, cout_out=0;
  - internal shift, carry and counter registers = 0.
- start accepted at edge E0. Edges E1..E_WIDTH process bits 0..WIDTH-1.
- After E_WIDTH: done=1, and sum_out/cout_out are valid.
- After E_WIDTH+1: done=0, ready=1.
- Latency: start to done = WIDTH+1 cycles.
- Throughput: one addition per WIDTH+2 cycles when start is held high.
- rst=1 in any state: at the next edge, all outputs return to reset values and the in-flight result is discarded; done is never pulsed.
- rst and start both high in the same cycle: rst wins.
- sum_out is not updated bit-by-bit. The internal result register is copied to sum_out only on the RUN->DONE edge.

## Configuration
- APPROX_ADD_EN defined: bits 0..APPROX_BITS-1 use the approximate cell, and the upper bits are exact.
- APPROX_ADD_EN undefined: every bit uses the exact cell, APPROX_BITS is ignored, and the result equals a_in+b_in+cin_in exactly.
- Handshake and timing are identical in both builds.

## Test plan
All scenarios use WIDTH=8 and APPROX_BITS=3.
- Macro off, a=0xFF, b=0x01, cin=1 -> sum_out=0x01, cout_out=1; done exactly 9 cycles after start accepted.
- Macro on, same stimulus -> sum_out=0xFF, cout_out=0 (low carry chain broken).
- Macro on, a=0x0F, b=0x01, cin=0 -> sum_out=0x0F, cout_out=0. Macro off -> 0x10, cout_out=0.
- Macro on, a=0xC8, b=0x88 -> sum_out=0x50, cout_out=1, matching the exact result. a=0xA5, b=0x5A -> 0xFF, cout_out=0 in both builds.
- start held high for 30 cycles with constant operands:
  - accepts occur at cycles 0, 10, 20;
  - busy is high for 8 cycles per operation;
  - done is a single-cycle pulse each time;
  - start toggling during RUN has no effect.
- rst=1 at the 4th RUN cycle:
  - next cycle: ready=1, busy=0, sum_out=0, cout_out=0;
  - no done pulse;
  - a fresh start then completes normally with a correct result.
